// File: rtl/sd_cmd_arbiter.sv
// SD CMD-line arbiter: fixed-priority registered grant with guard cycles,
// per-slot CMD routing of the owning engine, and a grant watchdog.
module sd_cmd_arbiter #(
  parameter  int NSRC   = 2,
  parameter  int NSLOT  = 2,
  parameter  int GUARD  = 8,
  parameter  int TOUT_W = 16,
  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic              SD_clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   src_req,
  input  logic [NSRC-1:0]   src_done,
  input  logic [NSRC-1:0]   src_cmd_en,
  input  logic [NSRC-1:0]   src_cmd,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic              slot_load,
  input  logic [NSLOT-1:0]  cmd_in,
  output logic [NSRC-1:0]   grant,
  output logic [NSLOT-1:0]  cmd_oe,
  output logic [NSLOT-1:0]  cmd_o,
  output logic              resp_o,
  output logic [SLOT_W-1:0] active_slot,
  output logic              busy,
  output logic              timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  localparam logic [TOUT_W-1:0] WD_MAX     = '1;
  localparam logic [TOUT_W-1:0] WD_EXP     = WD_MAX - TOUT_W'(1);
  localparam logic [7:0]        GUARD_LAST = 8'(GUARD - 1);
  localparam logic [SLOT_W:0]   NSLOT_L    = (SLOT_W + 1)'(NSLOT);

  logic [1:0]        state;
  logic [TOUT_W-1:0] wd_cnt;
  logic [7:0]        guard_cnt;
  logic              pend_vld;
  logic [SLOT_W-1:0] pend_slot;

  logic [NSRC-1:0]   req_pick;
  logic              any_req;
  logic              own_req;
  logic              own_done;
  logic              own_en;
  logic              own_cmd;
  logic              release_c;
  logic              expire_c;
  logic              sel_ok;
  logic [NSLOT-1:0]  oe_nxt;
  logic [NSLOT-1:0]  o_nxt;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    req_pick = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        req_pick    = '0;
        req_pick[i] = 1'b1;
      end
    end
  end

  assign any_req  = |src_req;
  assign own_req  = |(grant & src_req);
  assign own_done = |(grant & src_done);
  assign own_en   = |(grant & src_cmd_en);
  assign own_cmd  = |(grant & src_cmd);

  // A normal release (done or request withdrawn) masks a coincident expiry.
  assign release_c = own_done | ~own_req;
  assign expire_c  = (wd_cnt >= WD_EXP) & ~release_c;
  assign sel_ok    = ({1'b0, slot_sel} < NSLOT_L);

  always_comb begin
    oe_nxt = '0;
    o_nxt  = '1;
    if ((state == S_GRANT) && !release_c && !expire_c) begin
      oe_nxt[active_slot] = own_en;
      o_nxt[active_slot]  = own_cmd;
    end
  end

  assign resp_o = cmd_in[active_slot];
  assign busy   = (state != S_IDLE);

  always_ff @(posedge SD_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      cmd_oe      <= '0;
      cmd_o       <= '1;
      active_slot <= '0;
      timeout     <= 1'b0;
      pend_vld    <= 1'b0;
      wd_cnt      <= '0;
      guard_cnt   <= '0;
    end else begin
      timeout <= 1'b0;
      cmd_oe  <= oe_nxt;
      cmd_o   <= o_nxt;
      case (state)
        S_IDLE: begin
          if (slot_load) begin
            if (sel_ok) active_slot <= slot_sel;
            pend_vld <= 1'b0;
          end else if (pend_vld) begin
            active_slot <= pend_slot;
            pend_vld    <= 1'b0;
          end
          if (any_req) begin
            grant  <= req_pick;
            wd_cnt <= '0;
            state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + TOUT_W'(1);
          if (release_c || expire_c) begin
            grant     <= '0;
            guard_cnt <= '0;
            state     <= S_GUARD;
            timeout   <= expire_c;
          end
        end
        S_GUARD: begin
          if (guard_cnt == GUARD_LAST) state <= S_IDLE;
          else guard_cnt <= guard_cnt + 8'd1;
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
        end
      endcase
      if ((state != S_IDLE) && slot_load && sel_ok) pend_vld <= 1'b1;
    end
  end

  // Pending slot value is qualified by pend_vld, so it needs no reset.
  always_ff @(posedge SD_clk) begin
    if ((state != S_IDLE) && slot_load && sel_ok) pend_slot <= slot_sel;
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter: priority, routing, deferred slot change,
// watchdog and asynchronous reset.
module tb_sd_cmd_arbiter;

  localparam int NSRC   = 2;
  localparam int NSLOT  = 2;
  localparam int GUARD  = 8;
  localparam int TOUT_W = 4;

  logic       SD_clk;
  logic       rst;
  logic [1:0] src_req;
  logic [1:0] src_done;
  logic [1:0] src_cmd_en;
  logic [1:0] src_cmd;
  logic [0:0] slot_sel;
  logic       slot_load;
  logic [1:0] cmd_in;
  logic [1:0] grant;
  logic [1:0] cmd_oe;
  logic [1:0] cmd_o;
  logic       resp_o;
  logic [0:0] active_slot;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  sd_cmd_arbiter #(
    .NSRC  (NSRC),
    .NSLOT (NSLOT),
    .GUARD (GUARD),
    .TOUT_W(TOUT_W)
  ) dut (
    .SD_clk     (SD_clk),
    .rst        (rst),
    .src_req    (src_req),
    .src_done   (src_done),
    .src_cmd_en (src_cmd_en),
    .src_cmd    (src_cmd),
    .slot_sel   (slot_sel),
    .slot_load  (slot_load),
    .cmd_in     (cmd_in),
    .grant      (grant),
    .cmd_oe     (cmd_oe),
    .cmd_o      (cmd_o),
    .resp_o     (resp_o),
    .active_slot(active_slot),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial begin
    SD_clk = 1'b0;
    forever #80 SD_clk = ~SD_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL tb_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  task automatic step();
    @(posedge SD_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({grant, busy, cmd_oe, cmd_o, active_slot, timeout} !== {2'b00, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: grant=%b busy=%b cmd_oe=%b cmd_o=%b slot=%b tout=%b expected 00 0 00 11 0 0",
               grant, busy, cmd_oe, cmd_o, active_slot, timeout);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({grant, busy, cmd_oe, cmd_o} !== {2'b00, 1'b0, 2'b00, 2'b11}) begin
        failures++;
        $display("FAIL idle_cycle%0d: grant=%b busy=%b cmd_oe=%b cmd_o=%b expected 00 0 00 11",
                 i, grant, busy, cmd_oe, cmd_o);
      end
    end
  endtask

  task automatic test_priority();
    src_req = 2'b11;
    step();
    checks++;
    if ({grant, busy} !== {2'b01, 1'b1}) begin
      failures++;
      $display("FAIL prio_first: grant=%b busy=%b expected 01 1", grant, busy);
    end
    src_done = 2'b10;
    step();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL prio_nonowner_done: grant=%b expected 01", grant);
    end
    src_done = 2'b01;
    src_req  = 2'b10;
    step();
    src_done = 2'b00;
    checks++;
    if ({grant, busy, cmd_oe} !== {2'b00, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL prio_release: grant=%b busy=%b cmd_oe=%b expected 00 1 00", grant, busy, cmd_oe);
    end
    for (int i = 0; i < GUARD - 1; i++) begin
      step();
      checks++;
      if ({grant, busy} !== {2'b00, 1'b1}) begin
        failures++;
        $display("FAIL prio_guard%0d: grant=%b busy=%b expected 00 1", i, grant, busy);
      end
    end
    step();
    checks++;
    if ({grant, busy} !== {2'b00, 1'b0}) begin
      failures++;
      $display("FAIL prio_idle_gap: grant=%b busy=%b expected 00 0", grant, busy);
    end
    step();
    checks++;
    if (grant !== 2'b10) begin
      failures++;
      $display("FAIL prio_second: grant=%b expected 10", grant);
    end
    src_done = 2'b10;
    src_req  = 2'b00;
    step();
    src_done = 2'b00;
    repeat (GUARD + 1) step();
  endtask

  task automatic test_routing();
    logic [3:0] pat;
    pat        = 4'b0110;
    slot_sel   = 1'b1;
    slot_load  = 1'b1;
    src_req    = 2'b10;
    src_cmd_en = 2'b01;
    src_cmd    = 2'b00;
    step();
    slot_load = 1'b0;
    checks++;
    if ({active_slot, grant, cmd_oe} !== {1'b1, 2'b10, 2'b00}) begin
      failures++;
      $display("FAIL route_grant: slot=%b grant=%b cmd_oe=%b expected 1 10 00", active_slot, grant, cmd_oe);
    end
    for (int k = 0; k < 4; k++) begin
      src_cmd_en = 2'b11;
      src_cmd    = {pat[3-k], 1'b0};
      step();
      checks++;
      if ({cmd_oe, cmd_o} !== {2'b10, pat[3-k], 1'b1}) begin
        failures++;
        $display("FAIL route_pat%0d: cmd_oe=%b cmd_o=%b expected 10 %b1", k, cmd_oe, cmd_o, pat[3-k]);
      end
    end
    cmd_in = 2'b01;
    #1;
    checks++;
    if (resp_o !== 1'b0) begin
      failures++;
      $display("FAIL resp_low: resp_o=%b expected 0", resp_o);
    end
    cmd_in = 2'b10;
    #1;
    checks++;
    if (resp_o !== 1'b1) begin
      failures++;
      $display("FAIL resp_high: resp_o=%b expected 1", resp_o);
    end
    cmd_in = 2'b11;
  endtask

  task automatic test_deferred_slot();
    slot_sel  = 1'b1;
    slot_load = 1'b1;
    step();
    slot_sel = 1'b0;
    step();
    slot_load = 1'b0;
    checks++;
    if ({active_slot, grant} !== {1'b1, 2'b10}) begin
      failures++;
      $display("FAIL defer_hold: slot=%b grant=%b expected 1 10", active_slot, grant);
    end
    src_done   = 2'b10;
    src_req    = 2'b00;
    src_cmd_en = 2'b00;
    step();
    src_done = 2'b00;
    checks++;
    if ({active_slot, grant} !== {1'b1, 2'b00}) begin
      failures++;
      $display("FAIL defer_release: slot=%b grant=%b expected 1 00", active_slot, grant);
    end
    for (int i = 0; i < GUARD - 1; i++) begin
      step();
      checks++;
      if ({active_slot, busy} !== {1'b1, 1'b1}) begin
        failures++;
        $display("FAIL defer_guard%0d: slot=%b busy=%b expected 1 1", i, active_slot, busy);
      end
    end
    step();
    checks++;
    if ({active_slot, busy} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL defer_first_idle: slot=%b busy=%b expected 1 0", active_slot, busy);
    end
    step();
    checks++;
    if (active_slot !== 1'b0) begin
      failures++;
      $display("FAIL defer_applied: slot=%b expected 0", active_slot);
    end
  endtask

  task automatic test_watchdog();
    src_req    = 2'b01;
    src_cmd_en = 2'b01;
    src_cmd    = 2'b00;
    step();
    checks++;
    if ({grant, timeout} !== {2'b01, 1'b0}) begin
      failures++;
      $display("FAIL wd_grant: grant=%b timeout=%b expected 01 0", grant, timeout);
    end
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if ({grant, timeout} !== {2'b01, 1'b0}) begin
        failures++;
        $display("FAIL wd_hold%0d: grant=%b timeout=%b expected 01 0", i, grant, timeout);
      end
    end
    step();
    checks++;
    if ({timeout, grant, cmd_oe, busy} !== {1'b1, 2'b00, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL wd_expire: timeout=%b grant=%b cmd_oe=%b busy=%b expected 1 00 00 1",
               timeout, grant, cmd_oe, busy);
    end
    src_req = 2'b00;
    step();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_pulse_width: timeout=%b expected 0", timeout);
    end
    repeat (GUARD) step();

    src_req = 2'b01;
    step();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL wd2_grant: grant=%b expected 01", grant);
    end
    repeat (14) step();
    src_done = 2'b01;
    src_req  = 2'b00;
    step();
    src_done = 2'b00;
    checks++;
    if ({timeout, grant} !== {1'b0, 2'b00}) begin
      failures++;
      $display("FAIL wd2_done_wins: timeout=%b grant=%b expected 0 00", timeout, grant);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd2_no_late_pulse: timeout=%b expected 0", timeout);
    end
    repeat (GUARD) step();
  endtask

  task automatic test_async_reset();
    slot_sel   = 1'b1;
    slot_load  = 1'b1;
    src_req    = 2'b01;
    src_cmd_en = 2'b01;
    src_cmd    = 2'b01;
    step();
    slot_load = 1'b0;
    step();
    checks++;
    if ({active_slot, cmd_oe, grant} !== {1'b1, 2'b10, 2'b01}) begin
      failures++;
      $display("FAIL arst_pre: slot=%b cmd_oe=%b grant=%b expected 1 10 01", active_slot, cmd_oe, grant);
    end
    #20;
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_oe, cmd_o, grant, busy, active_slot} !== {2'b00, 2'b11, 2'b00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL arst_immediate: cmd_oe=%b cmd_o=%b grant=%b busy=%b slot=%b expected 00 11 00 0 0",
               cmd_oe, cmd_o, grant, busy, active_slot);
    end
    src_req    = 2'b00;
    src_cmd_en = 2'b00;
    src_cmd    = 2'b00;
    step();
    step();
    rst = 1'b0;
    src_req = 2'b01;
    step();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL arst_regrant: grant=%b expected 01", grant);
    end
    src_req = 2'b00;
    step();
    checks++;
    if ({grant, busy} !== {2'b00, 1'b1}) begin
      failures++;
      $display("FAIL req_drop_release: grant=%b busy=%b expected 00 1", grant, busy);
    end
    repeat (GUARD + 1) step();
  endtask

  initial begin
    rst        = 1'b1;
    src_req    = 2'b00;
    src_done   = 2'b00;
    src_cmd_en = 2'b00;
    src_cmd    = 2'b00;
    slot_sel   = 1'b0;
    slot_load  = 1'b0;
    cmd_in     = 2'b11;
    test_reset();
    test_priority();
    test_routing();
    test_deferred_slot();
    test_watchdog();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
